// File: rtl/bp_be_fpu_issue_sched_if.sv
// Control-only handshake between the FP issue stage, the FPU datapaths and
// the FP issue/writeback scheduler. Signal names are given from the
// scheduler's point of view.
interface bp_be_fpu_issue_sched_if
    #(parameter int reg_addr_width_p = 5)
    ();

    logic                        v_i;
    logic                        ready_o;
    logic                        long_i;
    logic [reg_addr_width_p-1:0] rd_i;
    logic                        flush_i;
    logic                        pipe_v_o;
    logic                        div_v_o;
    logic                        div_ready_i;
    logic                        div_done_i;
    logic                        wb_v_o;
    logic                        wb_sel_o;
    logic [reg_addr_width_p-1:0] wb_rd_o;

    modport slave (
        input  v_i, long_i, rd_i, flush_i, div_ready_i, div_done_i,
        output ready_o, pipe_v_o, div_v_o, wb_v_o, wb_sel_o, wb_rd_o
    );

    modport master (
        output v_i, long_i, rd_i, flush_i, div_ready_i, div_done_i,
        input  ready_o, pipe_v_o, div_v_o, wb_v_o, wb_sel_o, wb_rd_o
    );

endinterface

// File: rtl/bp_be_fpu_issue_sched.sv
// FP issue/writeback scheduler. Shares one FP writeback port between the
// fixed-latency FMA pipe and the iterative div/sqrt unit. Tracks in-flight
// destinations to block WAW hazards, gives the pipe writeback priority and
// bounds how long a finished div/sqrt result can be starved.
module bp_be_fpu_issue_sched
    #(parameter int latency_p        = 5,
      parameter int reg_addr_width_p = 5,
      parameter int starve_limit_p   = 4)
    (input  logic                   clk_i,
     input  logic                   reset_n_i,
     bp_be_fpu_issue_sched_if.slave fpu);

    localparam int age_width_lp = $clog2(starve_limit_p + 1);
    localparam logic [age_width_lp-1:0] starve_lim_lp = age_width_lp'(starve_limit_p);

    // div/sqrt tracking: KILL means the unit is still busy but its result
    // belongs to a flushed op and must be dropped when it arrives.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_KILL = 2'b10
    } div_state_e;

    div_state_e                  div_state_r, div_state_s;
    logic [reg_addr_width_p-1:0] div_rd_r;
    logic                        div_busy_s;
    logic                        div_live_s;

    logic                        shadow_v_r  [latency_p];
    logic [reg_addr_width_p-1:0] shadow_rd_r [latency_p];

    logic                        hold_v_r, hold_v_s;
    logic [reg_addr_width_p-1:0] hold_rd_r, hold_rd_s;
    logic                        hold_wb_s;

    logic [age_width_lp-1:0]     age_r, age_s;

    logic                        hazard_s;
    logic                        class_ok_s;
    logic                        ready_s;
    logic                        issue_s;
    logic                        pipe_v_s;
    logic                        div_v_s;

    logic                        wb_v_s;
    logic                        wb_sel_s;
    logic [reg_addr_width_p-1:0] wb_rd_s;

    // One destination comparison, qualified by the tracking entry's valid.
    function automatic logic rd_match(input logic                        v,
                                      input logic [reg_addr_width_p-1:0] a,
                                      input logic [reg_addr_width_p-1:0] b);
        return v & (a == b);
    endfunction

    assign div_busy_s = (div_state_r != DIV_IDLE);
    assign div_live_s = (div_state_r == DIV_BUSY);

    // WAW check of the offered destination against every live writer.
    always_comb begin
        hazard_s = rd_match(div_live_s, div_rd_r, fpu.rd_i)
                 | rd_match(hold_v_r, hold_rd_r, fpu.rd_i);
        for (int i = 0; i < latency_p; i++) begin
            hazard_s = hazard_s | rd_match(shadow_v_r[i], shadow_rd_r[i], fpu.rd_i);
        end
    end

    // Acceptance: per-class resource check, then hazard/flush/reset gating.
    always_comb begin
        class_ok_s = 1'b0;
        if (fpu.long_i) begin
            class_ok_s = ~div_busy_s & ~hold_v_r & fpu.div_ready_i;
        end else begin
            class_ok_s = (age_r < starve_lim_lp);
        end
        ready_s = reset_n_i & ~fpu.flush_i & ~hazard_s & class_ok_s;
    end

    assign issue_s      = fpu.v_i & ready_s;
    assign pipe_v_s     = issue_s & ~fpu.long_i;
    assign div_v_s      = issue_s & fpu.long_i;
    assign fpu.ready_o  = ready_s;
    assign fpu.pipe_v_o = pipe_v_s;
    assign fpu.div_v_o  = div_v_s;

    // Writeback arbitration: the pipe tail always wins, the hold fills gaps.
    always_comb begin
        wb_v_s    = 1'b0;
        wb_sel_s  = 1'b0;
        wb_rd_s   = '0;
        hold_wb_s = 1'b0;
        if (shadow_v_r[latency_p-1]) begin
            wb_v_s   = 1'b1;
            wb_sel_s = 1'b0;
            wb_rd_s  = shadow_rd_r[latency_p-1];
        end else if (hold_v_r) begin
            wb_v_s    = 1'b1;
            wb_sel_s  = 1'b1;
            wb_rd_s   = hold_rd_r;
            hold_wb_s = 1'b1;
        end else begin
            wb_v_s = 1'b0;
        end
    end

    assign fpu.wb_v_o   = wb_v_s;
    assign fpu.wb_sel_o = wb_sel_s;
    assign fpu.wb_rd_o  = wb_rd_s;

    // Pipe shadow: mirrors the FMA pipe occupancy; flush empties it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < latency_p; i++) begin
                shadow_v_r[i]  <= 1'b0;
                shadow_rd_r[i] <= '0;
            end
        end else begin
            shadow_v_r[0]  <= pipe_v_s & ~fpu.flush_i;
            shadow_rd_r[0] <= fpu.rd_i;
            for (int i = 1; i < latency_p; i++) begin
                shadow_v_r[i]  <= shadow_v_r[i-1] & ~fpu.flush_i;
                shadow_rd_r[i] <= shadow_rd_r[i-1];
            end
        end
    end

    // div/sqrt state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_state_r <= DIV_IDLE;
        end else begin
            div_state_r <= div_state_s;
        end
    end

    // div/sqrt next state: the unit cannot abort, so a flush only marks the
    // result for discard; a done pulse while idle is ignored.
    always_comb begin
        div_state_s = div_state_r;
        case (div_state_r)
            DIV_IDLE: begin
                if (div_v_s) begin
                    div_state_s = DIV_BUSY;
                end else begin
                    div_state_s = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                if (fpu.div_done_i) begin
                    div_state_s = DIV_IDLE;
                end else if (fpu.flush_i) begin
                    div_state_s = DIV_KILL;
                end else begin
                    div_state_s = DIV_BUSY;
                end
            end
            DIV_KILL: begin
                if (fpu.div_done_i) begin
                    div_state_s = DIV_IDLE;
                end else begin
                    div_state_s = DIV_KILL;
                end
            end
            default: begin
                div_state_s = DIV_IDLE;
            end
        endcase
    end

    // Destination of the op currently inside the div/sqrt unit.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_rd_r <= '0;
        end else if (div_v_s) begin
            div_rd_r <= fpu.rd_i;
        end else begin
            div_rd_r <= div_rd_r;
        end
    end

    // Hold next state: flush drops it, a live done loads it, a writeback
    // grant empties it. Done and hold writeback cannot coincide because a
    // div issue needs an empty hold.
    always_comb begin
        hold_v_s  = hold_v_r;
        hold_rd_s = hold_rd_r;
        if (fpu.flush_i) begin
            hold_v_s = 1'b0;
        end else if (fpu.div_done_i & div_live_s) begin
            hold_v_s  = 1'b1;
            hold_rd_s = div_rd_r;
        end else if (hold_wb_s) begin
            hold_v_s = 1'b0;
        end else begin
            hold_v_s = hold_v_r;
        end
    end

    // Hold register for a finished div/sqrt result awaiting the port.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_v_r  <= 1'b0;
            hold_rd_r <= '0;
        end else begin
            hold_v_r  <= hold_v_s;
            hold_rd_r <= hold_rd_s;
        end
    end

    // Starvation age: counts cycles a held result loses arbitration; it is
    // zeroed whenever the hold is (or is about to be) empty so pipe issue
    // resumes the cycle after the hold drains.
    always_comb begin
        age_s = age_r;
        if (~hold_v_r | fpu.flush_i | hold_wb_s) begin
            age_s = '0;
        end else if (age_r != starve_lim_lp) begin
            age_s = age_r + age_width_lp'(1);
        end else begin
            age_s = age_r;
        end
    end

    // Starvation age register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            age_r <= '0;
        end else begin
            age_r <= age_s;
        end
    end

endmodule

// File: tb/tb_bp_be_fpu_issue_sched.sv
// Directed bench for the FP issue/writeback scheduler (latency 5, starve
// limit 4). Inputs change 1ns after the rising edge; outputs are sampled a
// few ns later, well away from the next edge.
module tb_bp_be_fpu_issue_sched;

    localparam int lat_lp    = 5;
    localparam int aw_lp     = 5;
    localparam int starve_lp = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    logic       acc_hist [0:31];
    logic [4:0] rd_hist  [0:31];
    logic       exp_rdy;
    logic [4:0] cur_rd;
    int         n_acc;

    bp_be_fpu_issue_sched_if #(.reg_addr_width_p(aw_lp)) fpu_if ();

    bp_be_fpu_issue_sched #(
        .latency_p       (lat_lp),
        .reg_addr_width_p(aw_lp),
        .starve_limit_p  (starve_lp)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .fpu      (fpu_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_wb(input string tag, input logic v, input logic sel, input logic [4:0] rd);
        check_eq({tag, "_wb_v"}, 32'(fpu_if.wb_v_o), 32'(v));
        check_eq({tag, "_wb_sel"}, 32'(fpu_if.wb_sel_o), 32'(sel));
        check_eq({tag, "_wb_rd"}, 32'(fpu_if.wb_rd_o), 32'(rd));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic lng, input logic [4:0] rd);
        fpu_if.v_i    = v;
        fpu_if.long_i = lng;
        fpu_if.rd_i   = rd;
        #1;
    endtask

    task automatic drain(input int n);
        offer(1'b0, 1'b0, 5'd0);
        fpu_if.flush_i    = 1'b0;
        fpu_if.div_done_i = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        fpu_if.v_i         = 1'b1;
        fpu_if.long_i      = 1'b0;
        fpu_if.rd_i        = 5'd1;
        fpu_if.flush_i     = 1'b0;
        fpu_if.div_ready_i = 1'b1;
        fpu_if.div_done_i  = 1'b0;

        // Reset state: outputs forced low even with an op offered.
        #2;
        check_eq("rst_ready", 32'(fpu_if.ready_o), 32'd0);
        check_eq("rst_pipe_v", 32'(fpu_if.pipe_v_o), 32'd0);
        check_eq("rst_div_v", 32'(fpu_if.div_v_o), 32'd0);
        check_wb("rst", 1'b0, 1'b0, 5'd0);
        #10 reset_n = 1'b1;
        drain(2);

        // Back-to-back pipe ops rd=1 at t0, rd=2 at t1: writeback at t5, t6.
        offer(1'b1, 1'b0, 5'd1);
        check_eq("pipe0_ready", 32'(fpu_if.ready_o), 32'd1);
        check_eq("pipe0_pipe_v", 32'(fpu_if.pipe_v_o), 32'd1);
        check_eq("pipe0_div_v", 32'(fpu_if.div_v_o), 32'd0);
        tick();
        offer(1'b1, 1'b0, 5'd2);
        check_eq("pipe1_pipe_v", 32'(fpu_if.pipe_v_o), 32'd1);
        tick();
        offer(1'b0, 1'b0, 5'd0);
        for (int t = 2; t <= 7; t++) begin
            check_wb("pipe_lat", (t == 5 || t == 6), 1'b0,
                     (t == 5) ? 5'd1 : ((t == 6) ? 5'd2 : 5'd0));
            tick();
        end
        drain(3);

        // div rd=7 at t0, done at t10: hold writes back at t11, long ready at t12.
        offer(1'b1, 1'b1, 5'd7);
        check_eq("div_issue_div_v", 32'(fpu_if.div_v_o), 32'd1);
        check_eq("div_issue_pipe_v", 32'(fpu_if.pipe_v_o), 32'd0);
        tick();
        for (int t = 1; t <= 12; t++) begin
            fpu_if.div_done_i = (t == 10);
            offer(1'b0, 1'b1, 5'd8);
            check_eq("div_long_ready", 32'(fpu_if.ready_o), 32'(t == 12));
            check_wb("div_hold", (t == 11), (t == 11), (t == 11) ? 5'd7 : 5'd0);
            tick();
        end
        drain(3);

        // WAW hazards against pipe shadow, then against the busy div unit.
        offer(1'b1, 1'b0, 5'd9);
        check_eq("haz_pipe9_issue", 32'(fpu_if.pipe_v_o), 32'd1);
        tick();
        offer(1'b0, 1'b1, 5'd9);
        check_eq("haz_long9_ready", 32'(fpu_if.ready_o), 32'd0);
        offer(1'b0, 1'b1, 5'd10);
        check_eq("haz_long10_ready", 32'(fpu_if.ready_o), 32'd1);
        offer(1'b1, 1'b1, 5'd3);
        check_eq("haz_div3_issue", 32'(fpu_if.div_v_o), 32'd1);
        tick();
        offer(1'b0, 1'b0, 5'd3);
        check_eq("haz_pipe3_ready", 32'(fpu_if.ready_o), 32'd0);
        offer(1'b0, 1'b0, 5'd4);
        check_eq("haz_pipe4_ready", 32'(fpu_if.ready_o), 32'd1);
        tick();
        fpu_if.div_done_i = 1'b1;
        tick();
        fpu_if.div_done_i = 1'b0;
        check_wb("haz_hold3", 1'b1, 1'b1, 5'd3);
        tick();
        check_wb("haz_pipe9", 1'b1, 1'b0, 5'd9);
        drain(4);

        // Starvation: div rd=20 busy, pipe ops every cycle, done at k5.
        offer(1'b1, 1'b1, 5'd20);
        check_eq("starve_div_issue", 32'(fpu_if.div_v_o), 32'd1);
        tick();
        n_acc = 0;
        for (int k = 0; k <= 22; k++) begin
            fpu_if.div_done_i = (k == 5);
            cur_rd  = 5'(10 + (n_acc % 6));
            exp_rdy = !(k >= 10 && k <= 15);
            offer(k <= 17, 1'b0, cur_rd);
            if (k <= 17) begin
                check_eq("starve_ready", 32'(fpu_if.ready_o), 32'(exp_rdy));
                check_eq("starve_pipe_v", 32'(fpu_if.pipe_v_o), 32'(exp_rdy));
            end
            acc_hist[k] = (k <= 17) && exp_rdy;
            rd_hist[k]  = cur_rd;
            if (acc_hist[k]) n_acc++;
            if (k >= 5 && acc_hist[k-5]) begin
                check_wb("starve_pipe", 1'b1, 1'b0, rd_hist[k-5]);
            end else if (k == 15) begin
                check_wb("starve_hold", 1'b1, 1'b1, 5'd20);
            end else begin
                check_wb("starve_idle", 1'b0, 1'b0, 5'd0);
            end
            tick();
        end
        drain(3);

        // Flush with pipe rd=1,2 in flight and div rd=5 busy.
        offer(1'b1, 1'b1, 5'd5);
        check_eq("flush_div_issue", 32'(fpu_if.div_v_o), 32'd1);
        tick();
        offer(1'b1, 1'b0, 5'd1);
        tick();
        offer(1'b1, 1'b0, 5'd2);
        tick();
        fpu_if.flush_i = 1'b1;
        offer(1'b1, 1'b0, 5'd3);
        check_eq("flush_ready", 32'(fpu_if.ready_o), 32'd0);
        check_eq("flush_pipe_v", 32'(fpu_if.pipe_v_o), 32'd0);
        tick();
        fpu_if.flush_i = 1'b0;
        for (int t = 3; t <= 12; t++) begin
            fpu_if.div_done_i = (t == 6);
            offer(1'b0, 1'b1, 5'd6);
            check_eq("flush_no_wb", 32'(fpu_if.wb_v_o), 32'd0);
            if (t == 4) check_eq("flush_killed_busy", 32'(fpu_if.ready_o), 32'd0);
            if (t == 8) check_eq("flush_div_cleared", 32'(fpu_if.ready_o), 32'd1);
            tick();
        end
        drain(2);

        // Asynchronous reset mid-cycle with the shadow full.
        for (int i = 1; i <= 5; i++) begin
            offer(1'b1, 1'b0, 5'(i));
            tick();
        end
        offer(1'b1, 1'b0, 5'd6);
        check_wb("prerst", 1'b1, 1'b0, 5'd1);
        #1 reset_n = 1'b0;
        #1;
        check_wb("midrst", 1'b0, 1'b0, 5'd0);
        check_eq("midrst_ready", 32'(fpu_if.ready_o), 32'd0);
        check_eq("midrst_pipe_v", 32'(fpu_if.pipe_v_o), 32'd0);
        offer(1'b0, 1'b0, 5'd0);
        tick();
        #2 reset_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            check_eq("postrst_no_wb", 32'(fpu_if.wb_v_o), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
